soc_eoc_requester: RTL

//  Initiator side of the soc/eoc handshake: drives soc, watches eoc and samples the
//  16-bit result bus of a responder unit (e.g. the x*y search unit) for a run of requests.

---
 rtl/soc_eoc_requester.sv | 138 +++++++++++++
 1 files changed

// File: rtl/soc_eoc_requester.sv
// Purpose: initiator side of a soc/eoc handshake; runs N_REQ conversions and streams results out.
// Latency: soc rises the cycle after eoc=1 is seen idle; a result is pushed 1 cycle after eoc rise is seen.
// Backpressure: 4-deep FWFT result FIFO; when full the FSM holds in CAPTURE with soc=0 (no timeout).
//
// Ports:
//   clock, reset        rising-edge clock; asynchronous active-high reset
//   start/busy/done     run control: start pulse (IDLE only), busy while running, 1-cycle done
//   timeout             sticky phase-timeout flag, cleared by the next accepted start
//   soc/eoc/res_in      responder handshake and result bus
//   res_data/res_valid/res_ready  result stream (FIFO head)
//   req_cnt             requests completed in current/last run
module soc_eoc_requester #(
  parameter int N_REQ  = 32,
  parameter int DW     = 16,
  parameter int TO_CYC = 1000
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic          soc,
  input  logic          eoc,
  input  logic [DW-1:0] res_in,
  output logic [DW-1:0] res_data,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [7:0]    req_cnt
);

  localparam int PW = $clog2(TO_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RDY, S_SOC_HI, S_SOC_LO, S_CAPTURE, S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   phase_cnt;
  logic            phase_end;
  logic            start_acc;
  logic            to_set;
  logic            last_req;

  logic [DW-1:0]   mem [4];
  logic [1:0]      wr_ptr, rd_ptr;
  logic [2:0]      count;
  logic            fifo_full;
  logic            push, pop;

  // Phase counter saturates at its terminal value; it only matters in the
  // three waiting states, which always leave when it gets there.
  assign phase_end = (phase_cnt == PW'(TO_CYC - 1));
  assign last_req  = ((req_cnt + 8'd1) == 8'(N_REQ));

  assign fifo_full = (count == 3'd4);
  // Full is judged before any pop this cycle: a freed slot is written next cycle.
  assign push      = (state == S_CAPTURE) && !fifo_full;
  assign pop       = res_valid && res_ready;
  assign res_valid = (count != 3'd0);
  assign res_data  = mem[rd_ptr];

  assign busy = (state == S_WAIT_RDY) || (state == S_SOC_HI) ||
                (state == S_SOC_LO)   || (state == S_CAPTURE);
  assign done = (state == S_DONE);

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    to_set    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_nxt = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        if (eoc)            state_nxt = S_SOC_HI;
        else if (phase_end) begin to_set = 1'b1; state_nxt = S_DONE; end
      end
      S_SOC_HI: begin
        if (!eoc)           state_nxt = S_SOC_LO;
        else if (phase_end) begin to_set = 1'b1; state_nxt = S_DONE; end
      end
      S_SOC_LO: begin
        if (eoc)            state_nxt = S_CAPTURE;
        else if (phase_end) begin to_set = 1'b1; state_nxt = S_DONE; end
      end
      S_CAPTURE: begin
        if (!fifo_full) state_nxt = last_req ? S_DONE : S_WAIT_RDY;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      phase_cnt <= '0;
      soc       <= 1'b0;
      timeout   <= 1'b0;
      req_cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        phase_cnt <= '0;
      else if (!phase_end)
        phase_cnt <= phase_cnt + 1'b1;
      // Registered from the next state so soc is high exactly while in SOC_HI.
      soc <= (state_nxt == S_SOC_HI);
      if (start_acc) begin
        req_cnt <= 8'd0;
        timeout <= 1'b0;
      end
      if (to_set) timeout <= 1'b1;
      if (push)   req_cnt <= req_cnt + 8'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= res_in;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + 3'(push) - 3'(pop);
    end
  end

endmodule
